// File: rtl/tmds_decoder.sv
// Receive side of one TMDS channel: word alignment from control-token runs,
// then 10b->8b symbol decode with lock tracking.
module tmds_decoder #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 64,
  parameter int unsigned MAX_DATA_RUN   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_in,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned RunW  = $clog2(CTRL_RUN + 1);
  localparam int unsigned TmoW  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned DrunW = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e           state_q, state_d;
  logic [9:0]       prev_q;
  logic [9:0]       s1_q;
  logic [3:0]       offset_q, offset_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [DrunW-1:0] drun_q, drun_d;
  logic             stale_q, stale_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             de_q, de_d;

  logic [19:0]      win;
  logic [9:0]       q_al;
  logic             tok;
  logic [1:0]       tok_c;
  logic [7:0]       v;
  logic [7:0]       dec;
  logic [3:0]       offset_inc;
  logic [RunW-1:0]  run_nxt;
  logic [DrunW-1:0] drun_nxt;

  // Offset 0 selects the previous word; higher offsets slide toward tmds_in.
  assign win = {tmds_in, prev_q};

  always_comb begin
    q_al = prev_q;
    for (int k = 0; k < 10; k++) begin
      if (offset_q == 4'(k)) q_al = win[k +: 10];
    end
  end

  always_comb begin
    tok   = 1'b1;
    tok_c = 2'b00;
    case (s1_q)
      10'h354: tok_c = 2'b00;
      10'h0ab: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2ab: tok_c = 2'b11;
      default: tok = 1'b0;
    endcase
  end

  always_comb begin
    v      = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
    dec    = '0;
    dec[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = s1_q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end
  end

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    de_d   = 1'b0;
    if (state_q == StLocked) begin
      if (tok) begin
        ctrl_d = tok_c;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
      end
    end else begin
      ctrl_d = 2'b00;
    end
  end

  assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    drun_d   = drun_q;
    stale_d  = 1'b0;
    run_nxt  = '0;
    drun_nxt = '0;
    unique case (state_q)
      StSearch: begin
        // The word in s1 right after an offset change was aligned with the old offset.
        if (tok && !stale_q) run_nxt = run_q + 1'b1;
        if (run_nxt == RunW'(CTRL_RUN)) begin
          state_d = StLocked;
          run_d   = '0;
          tmo_d   = '0;
          drun_d  = '0;
        end else if (tmo_q == TmoW'(SEARCH_TIMEOUT - 1)) begin
          offset_d = offset_inc;
          tmo_d    = '0;
          run_d    = '0;
          stale_d  = 1'b1;
        end else begin
          run_d = run_nxt;
          tmo_d = tmo_q + 1'b1;
        end
      end
      StLocked: begin
        drun_nxt = tok ? '0 : drun_q + 1'b1;
        if (drun_nxt == DrunW'(MAX_DATA_RUN)) begin
          state_d  = StSearch;
          offset_d = offset_inc;
          run_d    = '0;
          tmo_d    = '0;
          drun_d   = '0;
          stale_d  = 1'b1;
        end else begin
          drun_d = drun_nxt;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      s1_q     <= '0;
      state_q  <= StSearch;
      offset_q <= '0;
      run_q    <= '0;
      tmo_q    <= '0;
      drun_q   <= '0;
      stale_q  <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
    end else begin
      prev_q   <= tmds_in;
      s1_q     <= q_al;
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      drun_q   <= drun_d;
      stale_q  <= stale_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = (state_q == StLocked);
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: a default instance and one with a short data-run limit,
// both checked every cycle against a behavioural model, plus directed literals.
module tb_tmds_decoder;

  localparam int CtrlRun  = 8;
  localparam int SearchTo = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] tmds_in = '0;
  logic [7:0] dat [2];
  logic [1:0] ctl [2];
  logic       den [2];
  logic       lck [2];
  logic [3:0] ofs [2];

  tmds_decoder dut_a (
    .clk(clk), .rst(rst), .tmds_in(tmds_in), .data(dat[0]), .ctrl(ctl[0]),
    .de(den[0]), .locked(lck[0]), .offset(ofs[0])
  );

  tmds_decoder #(.MAX_DATA_RUN(16)) dut_b (
    .clk(clk), .rst(rst), .tmds_in(tmds_in), .data(dat[1]), .ctrl(ctl[1]),
    .de(den[1]), .locked(lck[1]), .offset(ofs[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model state, one entry per instance.
  typedef struct {
    logic [9:0] prev, s1;
    bit         locked, skip, de;
    int         off, run, tmo, drun, max_drun;
    logic [7:0] data;
    logic [1:0] ctrl;
  } mdl_t;
  mdl_t m[2];

  function automatic bit token_of(input logic [9:0] s, output logic [1:0] c);
    c = 2'b00;
    case (s)
      10'h354: begin c = 2'b00; return 1'b1; end
      10'h0ab: begin c = 2'b01; return 1'b1; end
      10'h154: begin c = 2'b10; return 1'b1; end
      10'h2ab: begin c = 2'b11; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  // Undo the XOR/XNOR chain: each bit is the transition between neighbours of v.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] v;
    v = s[9] ? ~s[7:0] : s[7:0];
    return (v ^ {v[6:0], 1'b0}) ^ (s[8] ? 8'h00 : 8'hfe);
  endfunction

  task automatic model_reset(input int i);
    int keep;
    keep = m[i].max_drun;
    m[i] = '{prev: '0, s1: '0, locked: 0, skip: 0, de: 0, off: 0, run: 0, tmo: 0,
             drun: 0, max_drun: keep, data: '0, ctrl: '0};
  endtask

  task automatic model_clock(input int i, input logic [9:0] din);
    logic [1:0] c;
    bit         tok;
    logic [19:0] w;
    tok = token_of(m[i].s1, c);
    if (m[i].locked) begin
      m[i].de = !tok;
      if (tok) m[i].ctrl = c;
      else     m[i].data = decode(m[i].s1);
    end else begin
      m[i].de   = 0;
      m[i].ctrl = 2'b00;
    end
    w         = {din, m[i].prev};
    m[i].s1   = 10'(w >> m[i].off);
    m[i].prev = din;
    if (!m[i].locked) begin
      if (tok && !m[i].skip) m[i].run++;
      else                   m[i].run = 0;
      m[i].skip = 0;
      if (m[i].run == CtrlRun) begin
        m[i].locked = 1; m[i].run = 0; m[i].tmo = 0;
      end else if (m[i].tmo == SearchTo - 1) begin
        m[i].off = (m[i].off + 1) % 10; m[i].tmo = 0; m[i].run = 0; m[i].skip = 1;
      end else begin
        m[i].tmo++;
      end
    end else begin
      if (tok) m[i].drun = 0;
      else     m[i].drun++;
      if (m[i].drun == m[i].max_drun) begin
        m[i].locked = 0; m[i].off = (m[i].off + 1) % 10;
        m[i].drun = 0; m[i].run = 0; m[i].tmo = 0; m[i].skip = 1;
      end
    end
  endtask

  task automatic cmp_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d.data", i),   dat[i], m[i].data);
      chk($sformatf("m%0d.ctrl", i),   ctl[i], m[i].ctrl);
      chk($sformatf("m%0d.de", i),     den[i], m[i].de);
      chk($sformatf("m%0d.locked", i), lck[i], m[i].locked);
      chk($sformatf("m%0d.offset", i), ofs[i], m[i].off);
    end
  endtask

  // One symbol clock: drive, let the edge happen, advance model, compare at negedge.
  task automatic step(input logic [9:0] w);
    tmds_in = w;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset(i);
      else     model_clock(i, w);
    end
    @(negedge clk);
    cmp_model();
  endtask

  int enc_cnt = 0;

  task automatic tmds_enc(input bit en, input logic [1:0] c, input logic [7:0] d,
                          output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1, n0;
    if (!en) begin
      enc_cnt = 0;
      case (c)
        2'd0:    q = 10'h354;
        2'd1:    q = 10'h0ab;
        2'd2:    q = 10'h154;
        default: q = 10'h2ab;
      endcase
      return;
    end
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int b = 1; b < 8; b++) qm[b] = qm[b-1] ~^ d[b];
      qm[8] = 1'b0;
    end else begin
      for (int b = 1; b < 8; b++) qm[b] = qm[b-1] ^ d[b];
      qm[8] = 1'b1;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (enc_cnt == 0 || n1 == n0) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8]) enc_cnt += n1 - n0;
      else       enc_cnt += n0 - n1;
    end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + n0 - n1;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(!qm[8]) + n1 - n0;
    end
  endtask

  // Expected symbol per driven word; outputs show it two edges later.
  typedef struct {
    bit         de;
    logic [7:0] d;
    logic [1:0] c;
  } sym_t;
  sym_t hist[$];

  task automatic send(input logic [9:0] w, input bit sde, input logic [7:0] sd,
                      input logic [1:0] sc, input bit en);
    sym_t s;
    s.de = sde; s.d = sd; s.c = sc;
    hist.push_back(s);
    step(w);
    if (en && hist.size() >= 3) begin
      s = hist[hist.size() - 3];
      chk("lat_de", den[0], s.de);
      if (s.de) chk("lat_data", dat[0], s.d);
      else      chk("lat_ctrl", ctl[0], s.c);
    end
  endtask

  task automatic do_reset(input bit mid);
    if (mid) #2;
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_data", dat[i], 0);
      chk("rst_ctrl", ctl[i], 0);
      chk("rst_de", den[i], 0);
      chk("rst_locked", lck[i], 0);
      chk("rst_offset", ofs[i], 0);
    end
    step(10'h000);
    step(10'h000);
    rst     = 1'b0;
    enc_cnt = 0;
    hist.delete();
  endtask

  // Lock must appear exactly after the edge that sees the 8th token in s1.
  task automatic lock_run(input int n);
    for (int k = 0; k < n; k++) begin
      send(10'h354, 0, 8'h00, 2'b00, 1);
      chk("lock_timing", lck[0], (k >= CtrlRun + 1));
    end
  endtask

  logic [9:0] w, e, prev_e;

  initial begin
    m[0].max_drun = 4096;
    m[1].max_drun = 16;
    #1;
    do_reset(0);

    // Aligned loopback: 16 blanking tokens then a 0..255 data ramp.
    for (int k = 0; k < 16; k++) begin
      tmds_enc(0, 2'b00, 8'h00, w);
      send(w, 0, 8'h00, 2'b00, 1);
      chk("lock_rise", lck[0], (k >= CtrlRun + 1));
    end
    chk("aligned_offset", ofs[0], 0);
    for (int j = 0; j < 256; j++) begin
      tmds_enc(1, 2'b00, 8'(j), w);
      send(w, 1, 8'(j), 2'b00, 1);
    end
    for (int j = 0; j < 2; j++) begin
      tmds_enc(0, 2'b00, 8'h00, w);
      send(w, 0, 8'h00, 2'b00, 1);
    end
    chk("ramp_last", dat[0], 8'hff);

    // Raw tokens and fixed data vectors on the locked default instance.
    send(10'h354, 0, 8'h00, 2'b00, 1);
    send(10'h0ab, 0, 8'h00, 2'b01, 1);
    send(10'h154, 0, 8'h00, 2'b10, 1);
    chk("tok_00", ctl[0], 2'b00);
    send(10'h2ab, 0, 8'h00, 2'b11, 1);
    chk("tok_01", ctl[0], 2'b01);
    send(10'h100, 1, 8'h00, 2'b00, 1);
    chk("tok_10", ctl[0], 2'b10);
    send(10'h2ff, 1, 8'hfe, 2'b00, 1);
    chk("tok_11", ctl[0], 2'b11);
    send(10'h354, 0, 8'h00, 2'b00, 1);
    chk("vec_100_de", den[0], 1);
    chk("vec_100", dat[0], 8'h00);
    send(10'h354, 0, 8'h00, 2'b00, 1);
    chk("vec_2ff", dat[0], 8'hfe);

    // Loss of lock on the MAX_DATA_RUN=16 instance.
    do_reset(0);
    for (int k = 0; k < 32; k++) begin
      if (k < 12) send(10'h354, 0, 8'h00, 2'b00, 1);
      else        send(10'h100, 1, 8'h00, 2'b00, 1);
      if (k == 28) chk("lol_before", lck[1], 1);
      if (k == 29) begin
        chk("lol_fall", lck[1], 0);
        chk("lol_offset", ofs[1], 1);
      end
      if (k >= 30) chk("lol_de_forced", den[1], 0);
    end
    chk("lol_a_held", lck[0], 1);

    // Asynchronous reset while streaming data, then a full re-lock.
    for (int k = 0; k < 3; k++) send(10'h2ff, 1, 8'hfe, 2'b00, 1);
    chk("pre_rst_de", den[0], 1);
    chk("pre_rst_data", dat[0], 8'hfe);
    do_reset(1);
    lock_run(12);

    // Stream delayed by 3 bits: offset walks 0..3, then locks at 3.
    do_reset(0);
    prev_e = '0;
    for (int n = 0; n < 270; n++) begin
      if (n < 230) tmds_enc(0, 2'b01, 8'h00, e);
      else         tmds_enc(1, 2'b00, 8'(8'h10 + n * 7), e);
      w      = {e[6:0], prev_e[9:7]};
      prev_e = e;
      if (n < 230) send(w, 0, 8'h00, 2'b01, n >= 203);
      else         send(w, 1, 8'(8'h10 + n * 7), 2'b00, 1);
      if (n == 62)  chk("shift_off0", ofs[0], 0);
      if (n == 63)  chk("shift_off1", ofs[0], 1);
      if (n == 127) chk("shift_off2", ofs[0], 2);
      if (n == 191) chk("shift_off3", ofs[0], 3);
      if (n == 199) chk("shift_unlocked", lck[0], 0);
      if (n == 200) chk("shift_locked", lck[0], 1);
    end
    chk("shift_final_off", ofs[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
